acc_cpu_core: RTL and testbench

//  Parametrised multi-cycle accumulator CPU core: LOAD/STORE/ADD/SUBT/SKIPCOND/JUMP/CLEAR/HALT ISA.

---
 rtl/acc_cpu_pkg.sv | 10 +
 rtl/acc_cpu_alu.sv | 19 +
 rtl/acc_cpu_core.sv | 97 +++++++++
 tb/tb_acc_cpu_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: opcodes, SKIPCOND condition codes and FSM state encoding shared by acc_cpu_core and acc_cpu_alu
package acc_cpu_pkg;
  localparam logic [3:0] OP_HALT = 4'h0, OP_ADD = 4'h1, OP_SUBT = 4'h2, OP_LOAD = 4'h3, OP_STORE = 4'h4,
    OP_SKIPCOND = 4'h6, OP_JUMP = 4'h7, OP_CLEAR = 4'h8, OP_ADDI = 4'h9, OP_JUMPI = 4'hA;
  localparam logic [1:0] SK_NEG = 2'b00, SK_ZERO = 2'b01, SK_POS = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC_RD, S_EXEC_WR, S_INDIR, S_HALT} state_t;
  function automatic logic base_op(input logic [3:0] op);
    return op inside {OP_HALT, OP_ADD, OP_SUBT, OP_LOAD, OP_STORE, OP_SKIPCOND, OP_JUMP, OP_CLEAR};
  endfunction
endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: accumulator arithmetic (LOAD/ADD/SUBT/ADDI) and SKIPCOND evaluation, purely combinational
module acc_cpu_alu import acc_cpu_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [1:0]        cond,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] result,
  output logic              skip
);
  logic neg, zero;
  always_comb begin
    neg = acc[DATA_W-1];
    zero = acc == '0;
    result = op == OP_LOAD ? rdata : op == OP_SUBT ? acc - rdata : acc + rdata;
    skip = cond == SK_NEG ? neg : cond == SK_ZERO ? zero : cond == SK_POS ? !neg && !zero : 1'b0;
  end
endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU with a single-outstanding req/ready memory port.
// Defining ACC_CPU_INDIRECT_EN adds ADDI/JUMPI through the INDIR pointer-read state.
module acc_cpu_core import acc_cpu_pkg::*; #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out
);
  state_t state, next;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir, acc, result;
  logic [3:0] opcode;
  logic [ADDR_W-1:0] operand;
  logic ill, legal, ind_op, skip;
  assign opcode = ir[DATA_W-1 -: 4];
  assign operand = ir[ADDR_W-1:0];
`ifdef ACC_CPU_INDIRECT_EN
  assign ind_op = opcode inside {OP_ADDI, OP_JUMPI};
`else
  assign ind_op = 1'b0;
`endif
  assign legal = base_op(opcode) || ind_op;
  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op(opcode), .cond(operand[ADDR_W-1 -: 2]), .acc(acc), .rdata(mem_rdata), .result(result), .skip(skip)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      S_IDLE:    next = run ? S_FETCH : S_IDLE;
      S_FETCH:   next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  next = !legal || opcode == OP_HALT ? S_HALT :
                        opcode inside {OP_ADD, OP_SUBT, OP_LOAD} ? S_EXEC_RD :
                        opcode == OP_STORE ? S_EXEC_WR :
                        ind_op ? S_INDIR : S_FETCH;
      S_EXEC_RD: next = mem_ready ? S_FETCH : S_EXEC_RD;
      S_EXEC_WR: next = mem_ready ? S_FETCH : S_EXEC_WR;
`ifdef ACC_CPU_INDIRECT_EN
      S_INDIR:   next = !mem_ready ? S_INDIR : opcode == OP_ADDI ? S_EXEC_RD : S_FETCH;
`endif
      default:   next = S_HALT;
    endcase
  end
  always_comb begin
    mem_req = state inside {S_FETCH, S_EXEC_RD, S_EXEC_WR, S_INDIR};
    mem_we = state == S_EXEC_WR;
    mem_addr = state == S_FETCH ? pc : mem_req ? operand : '0;
    mem_wdata = mem_we ? acc : '0;
  end
  // INDIR overwrites the IR operand with the fetched pointer so EXEC_RD can reuse its address path
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= RESET_PC;
      ir <= '0;
      acc <= '0;
      ill <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + ADDR_W'(1);
        end
        S_DECODE: begin
          pc <= opcode == OP_JUMP ? operand : opcode == OP_SKIPCOND && skip ? pc + ADDR_W'(1) : pc;
          acc <= opcode == OP_CLEAR ? '0 : acc;
          ill <= ill || !legal;
        end
        S_EXEC_RD: if (mem_ready) acc <= result;
`ifdef ACC_CPU_INDIRECT_EN
        S_INDIR: if (mem_ready) begin
          if (opcode == OP_JUMPI) pc <= mem_rdata[ADDR_W-1:0];
          else ir[ADDR_W-1:0] <= mem_rdata[ADDR_W-1:0];
        end
`endif
        default: ;
      endcase
    end
  assign halted = state == S_HALT;
  assign illegal = ill;
  assign pc_out = pc;
  assign acc_out = acc;
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: ISA-level reference model feeds an expected bus-transaction queue; a monitor checks every handshake.
module tb_acc_cpu_core;
  localparam int AW = 12, DW = 16;
  localparam logic [AW-1:0] RPC = 12'hFFF;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} txn_t;
  logic clk = 0, rst = 0, run = 0, rdy_q = 1, hv = 0;
  logic mem_req, mem_we, mem_ready, halted, illegal;
  logic [AW-1:0] mem_addr, pc_out, exp_pc;
  logic [DW-1:0] mem_wdata, mem_rdata, acc_out, exp_acc;
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] rm [4096];
  logic exp_ill;
  int n_chk = 0, n_fail = 0, rdy_mode = 0, stalls = 0, exp_cyc = 0;
  txn_t exp_q[$];
  txn_t held, e;
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  assign mem_ready = rdy_mode == 2 ? !mem_we : rdy_q;
  acc_cpu_core #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted),
    .illegal(illegal), .pc_out(pc_out), .acc_out(acc_out)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst && mem_req && mem_ready && mem_we) mem[mem_addr] = mem_wdata;
    #1 rdy_q = rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (!rst) hv = 0;
    else begin
      if (hv && mem_req) chk("stall_stable", {mem_we, mem_addr, mem_wdata}, held);
      if (mem_req && !mem_ready) stalls++;
      hv = mem_req && !mem_ready;
      held = {mem_we, mem_addr, mem_wdata};
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_txn: got we=%0b addr=0x%0h expected no access", mem_we, mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("bus_we", mem_we, e.we);
          chk("bus_addr", mem_addr, e.addr);
          if (e.we) chk("bus_wdata", mem_wdata, e.data);
        end
      end
    end
  end
  task automatic model();
    logic [AW-1:0] pc = RPC, a;
    logic [DW-1:0] acc = 0, ir;
    logic ill = 0;
    int cyc = 0;
    bit done = 0;
    for (int i = 0; i < 4096; i++) rm[i] = mem[i];
    for (int s = 0; s < 3000 && !done; s++) begin
      ir = rm[pc];
      exp_q.push_back({1'b0, pc, ir});
      pc = pc + 12'd1;
      a = ir[AW-1:0];
      cyc += 2;
      case (ir[15:12])
        4'h0: done = 1;
        4'h1: begin exp_q.push_back({1'b0, a, rm[a]}); acc = acc + rm[a]; cyc++; end
        4'h2: begin exp_q.push_back({1'b0, a, rm[a]}); acc = acc - rm[a]; cyc++; end
        4'h3: begin exp_q.push_back({1'b0, a, rm[a]}); acc = rm[a]; cyc++; end
        4'h4: begin exp_q.push_back({1'b1, a, acc}); rm[a] = acc; cyc++; end
        4'h6: if (a[11:10] == 0 ? $signed(acc) < 16'sd0 : a[11:10] == 1 ? acc == 0 :
                  a[11:10] == 2 ? $signed(acc) > 16'sd0 : 1'b0) pc = pc + 12'd1;
        4'h7: pc = a;
        4'h8: acc = 0;
        default: begin ill = 1; done = 1; end
      endcase
    end
    exp_acc = acc;
    exp_pc = pc;
    exp_ill = ill;
    exp_cyc = cyc;
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 0;
    mem[RPC] = 16'h8000;
  endtask
  task automatic do_reset();
    rst = 0;
    run = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    exp_q.delete();
  endtask
  task automatic run_prog(input string nm, input int mode);
    int cyc = 0, diffs = 0;
    rdy_mode = mode;
    do_reset();
    model();
    @(posedge clk);
    #1 run = 1;
    stalls = 0;
    @(posedge clk);
    #1 run = 0;
    chk({nm, "_first_req"}, mem_req, 1);
    while (!halted && cyc < 20000) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({nm, "_halted"}, halted, 1);
    chk({nm, "_cycles"}, cyc, exp_cyc + stalls);
    chk({nm, "_illegal"}, illegal, exp_ill);
    chk({nm, "_acc"}, acc_out, exp_acc);
    chk({nm, "_pc"}, pc_out, exp_pc);
    chk({nm, "_txn_left"}, exp_q.size(), 0);
    for (int i = 0; i < 4096; i++) if (mem[i] !== rm[i]) diffs++;
    chk({nm, "_mem_diffs"}, diffs, 0);
  endtask
  task automatic load_fib();
    clear_mem();
    mem[0] = 16'h3100; mem[1] = 16'h1101; mem[2] = 16'h4104; mem[3] = 16'h3101;
    mem[4] = 16'h4100; mem[5] = 16'h3104; mem[6] = 16'h4101; mem[7] = 16'h3102;
    mem[8] = 16'h1103; mem[9] = 16'h4102; mem[10] = 16'h6400; mem[11] = 16'h7000; mem[12] = 16'h0000;
    mem[12'h100] = 1; mem[12'h101] = 1; mem[12'h102] = 5; mem[12'h103] = 16'hFFFF;
  endtask
  task automatic load_rand();
    clear_mem();
    for (int i = 0; i < 16; i++) mem[12'h100 + i] = 16'($urandom);
    for (int i = 0; i < 24; i++) begin
      int r = $urandom_range(0, 9);
      logic [11:0] a = 12'h100 + 12'($urandom_range(0, 15));
      case (r)
        0, 1: mem[i] = {4'h1, a};
        2: mem[i] = {4'h2, a};
        3, 4: mem[i] = {4'h3, a};
        5, 6: mem[i] = {4'h4, a};
        7: mem[i] = {4'h6, 2'($urandom_range(0, 3)), 10'h0};
        8: mem[i] = 16'h8000;
        default: mem[i] = {4'h7, 12'(i + 1 + $urandom_range(0, 2))};
      endcase
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit expected end of test");
    $fatal(1, "watchdog");
  end
  initial begin
    int nreq, w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_pc", pc_out, RPC);
    chk("rst_acc", acc_out, 0);
    load_fib();
    run_prog("fib", 0);
    chk("fib_sum", mem[12'h104], 13);
    chk("fib_ctr", mem[12'h102], 0);
    load_fib();
    run_prog("fib_stall", 1);
    chk("fib_stall_sum", mem[12'h104], 13);
    clear_mem();
    mem[0] = 16'h3100; mem[1] = 16'h1101; mem[2] = 16'h4110; mem[3] = 16'h6000; mem[4] = 16'h0000;
    mem[5] = 16'h8000; mem[6] = 16'h2101; mem[7] = 16'h4111; mem[8] = 16'h6800; mem[9] = 16'h700B;
    mem[10] = 16'hB000; mem[11] = 16'h0000;
    mem[12'h100] = 16'h7FFF; mem[12'h101] = 16'h0001;
    run_prog("arith", 0);
    chk("arith_ovf", mem[12'h110], 16'h8000);
    chk("arith_sub", mem[12'h111], 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      load_rand();
      run_prog("rand", 1);
    end
    clear_mem();
    mem[0] = 16'h3100; mem[1] = 16'hB123; mem[12'h100] = 16'h0005;
    run_prog("illegal", 0);
    nreq = 0;
    repeat (3) begin
      run = 1;
      @(posedge clk);
      #1 run = 0;
      repeat (5) begin
        @(posedge clk);
        #1 nreq += int'(mem_req);
      end
    end
    chk("halt_no_req", nreq, 0);
    chk("halt_sticky", {halted, illegal}, 2'b11);
    clear_mem();
    mem[0] = 16'h4120; mem[12'h120] = 16'h1234;
    rdy_mode = 2;
    do_reset();
    exp_q.push_back({1'b0, RPC, 16'h8000});
    exp_q.push_back({1'b0, 12'h000, 16'h4120});
    @(posedge clk);
    #1 run = 1;
    @(posedge clk);
    #1 run = 0;
    w = 0;
    while (!(mem_req && mem_we) && w < 20) begin
      @(posedge clk);
      #1 w++;
    end
    chk("store_stalled", {mem_req, mem_we}, 2'b11);
    repeat (2) @(posedge clk);
    #3 rst = 0;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_pc", pc_out, RPC);
    chk("async_rst_acc", acc_out, 0);
    @(posedge clk);
    #1;
    chk("async_rst_mem", mem[12'h120], 16'h1234);
    chk("async_rst_txn_left", exp_q.size(), 0);
    rst = 1;
    rdy_mode = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
